rr_mux_arb: RTL and testbench

Parametrised N-channel, W-bit registered selector that resolves contention among several sources for one shared output. Arbitration is round-robin or fixed-priority, selected at run time, so each output is driven by exactly one granted channel. Each input channel and the output use a valid/ready handshake. The block sits between multiple producer blocks and a single downstream consumer.

---
 rtl/rr_mux_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 60 ++++++
 rtl/rr_mux_arb.sv | 83 ++++++++
 tb/tb_rr_mux_arb.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// Shared types for the round-robin / fixed-priority output selector.
package rr_mux_pkg;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    typedef enum logic {RR = 1'b0, FIXED = 1'b1} prio_mode_t;

endpackage

// File: rtl/rr_arbiter.sv
// Grant selection for rr_mux_arb: rotating or lowest-index priority, owns the
// round-robin pointer.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter  int N_CH = 4,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] req,
    input  prio_mode_t      mode,
    input  logic            advance,
    output logic [N_CH-1:0] gnt,
    output logic [CH_W-1:0] gnt_idx
);

    logic [CH_W-1:0] r_ptr;
    logic            w_found;
    logic [CH_W-1:0] w_idx;
    int              w_k;

    // Pick the winner; round-robin scans ptr+1 .. ptr so the last winner goes last.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_k     = 0;
        if (mode == FIXED) begin
            for (int i = 0; i < N_CH; i++) begin
                if (!w_found && req[i]) begin
                    w_found = 1'b1;
                    w_idx   = CH_W'(i);
                end
            end
        end else begin
            for (int off = 1; off <= N_CH; off++) begin
                w_k = int'(r_ptr) + off;
                if (w_k >= N_CH) w_k = w_k - N_CH;
                if (!w_found && req[w_k]) begin
                    w_found = 1'b1;
                    w_idx   = CH_W'(w_k);
                end
            end
        end
    end

    // One-hot grant, empty when nobody requests.
    always_comb begin
        gnt = '0;
        if (w_found) gnt[w_idx] = 1'b1;
        gnt_idx = w_idx;
    end

    // Pointer follows every accepted winner; reset value makes channel 0 win first.
    always_ff @(posedge clk) begin
        if (rst)          r_ptr <= CH_W'(N_CH - 1);
        else if (advance) r_ptr <= w_idx;
    end

endmodule

// File: rtl/rr_mux_arb.sv
// N-channel valid/ready selector with a one-entry output register.
module rr_mux_arb
    import rr_mux_pkg::*;
#(
    parameter  int N_CH = 4,
    parameter  int W    = 8,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prio_mode,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH*W-1:0] in_data,
    output logic [N_CH-1:0]   in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [CH_W-1:0]   out_ch,
    input  logic              out_ready
);

    state_t          r_state, w_state_nxt;
    logic [W-1:0]    r_data;
    logic [CH_W-1:0] r_ch;
    logic [N_CH-1:0] w_gnt;
    logic [CH_W-1:0] w_gnt_idx;
    logic            w_load_ok;
    logic            w_xfer;
    logic [W-1:0]    w_sel_data;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (in_valid),
        .mode    (prio_mode_t'(prio_mode)),
        .advance (w_xfer),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    // Grant only when the register can take a word; reset blocks any accept.
    always_comb begin
        w_load_ok = (r_state == EMPTY) || out_ready;
        in_ready  = (w_load_ok && !rst) ? w_gnt : '0;
        w_xfer    = |(in_valid & in_ready);
    end

    // Data mux driven by the one-hot grant.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_gnt[i]) w_sel_data = w_sel_data | in_data[i*W +: W];
        end
    end

    // Next state: refill wins over drain, so drain+refill stays FULL.
    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer)         w_state_nxt = FULL;
        else if (out_ready) w_state_nxt = EMPTY;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= EMPTY;
        else     r_state <= w_state_nxt;
    end

    // Output word and source index; held unless a new word is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_ch   <= '0;
        end else if (w_xfer) begin
            r_data <= w_sel_data;
            r_ch   <= w_gnt_idx;
        end
    end

    assign out_valid = (r_state == FULL);
    assign out_data  = r_data;
    assign out_ch    = r_ch;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb; expected words queued by stimulus, checked by a monitor.
module tb_rr_mux_arb;

    localparam int N_CH = 4;
    localparam int W    = 8;
    localparam int CH_W = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 prio_mode;
    logic [N_CH-1:0]      in_valid;
    logic [N_CH-1:0][W-1:0] in_data;
    logic [N_CH-1:0]      in_ready;
    logic                 out_valid;
    logic [W-1:0]         out_data;
    logic [CH_W-1:0]      out_ch;
    logic                 out_ready;

    int checks = 0;
    int errors = 0;
    logic [CH_W+W-1:0] exp_q[$];
    logic [CH_W+W-1:0] mon_e;

    always #5 clk = ~clk;

    rr_mux_arb #(.N_CH(N_CH), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .prio_mode (prio_mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input int d);
        exp_q.push_back({CH_W'(ch), W'(d)});
    endtask

    // A word is consumed at the next edge when valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got ch %0d data %0h expected nothing", out_ch, out_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({out_ch, out_data} !== mon_e) begin
                    errors++;
                    $display("FAIL sb_word: got ch %0d data %0h expected ch %0d data %0h",
                             out_ch, out_data, mon_e[CH_W+W-1:W], mon_e[W-1:0]);
                end
            end
        end
    end

    logic [N_CH-1:0] rr_rdy [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        // Reset with every channel requesting
        rst       = 1'b1;
        prio_mode = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        #1;
        chk("rst_in_ready0", in_ready, 4'b0000);
        tick();
        chk("rst_in_ready1", in_ready, 4'b0000);
        tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_ch", out_ch, 2'd0);
        chk("rst_in_ready2", in_ready, 4'b0000);

        // Round-robin over all four channels
        rst = 1'b0;
        #1;
        chk("rr_first_grant", in_ready, 4'b0001);
        push(0, 8'h10); push(1, 8'h11); push(2, 8'h12); push(3, 8'h13); push(0, 8'h10);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_out_ch", out_ch, 32'(i));
            chk("rr_in_ready", in_ready, rr_rdy[i]);
        end
        tick();
        chk("rr_wrap_ch", out_ch, 2'd0);
        in_valid = 4'b0000;
        tick();
        chk("drain_empty", out_valid, 1'b0);

        // Backpressure hold, then same-cycle refill
        in_valid   = 4'b0100;
        in_data[2] = 8'hA5;
        out_ready  = 1'b0;
        #1;
        chk("bp_grant", in_ready, 4'b0100);
        push(2, 8'hA5);
        repeat (3) begin
            tick();
            chk("bp_data", out_data, 8'hA5);
            chk("bp_ch", out_ch, 2'd2);
            chk("bp_in_ready", in_ready, 4'b0000);
        end
        in_valid   = 4'b0010;
        in_data[1] = 8'h3C;
        out_ready  = 1'b1;
        #1;
        chk("refill_grant", in_ready, 4'b0010);
        push(1, 8'h3C);
        tick();
        chk("refill_data", out_data, 8'h3C);
        chk("refill_ch", out_ch, 2'd1);

        // Fixed priority starves channel 3, then round-robin hands it over
        prio_mode  = 1'b1;
        in_valid   = 4'b1010;
        in_data[3] = 8'h33;
        #1;
        chk("fix_grant", in_ready, 4'b0010);
        repeat (3) begin
            push(1, 8'h3C);
            tick();
            chk("fix_ch", out_ch, 2'd1);
            chk("fix_in_ready", in_ready, 4'b0010);
        end
        prio_mode = 1'b0;
        #1;
        chk("mode_switch_grant", in_ready, 4'b1000);
        push(3, 8'h33);
        tick();
        chk("mode_switch_ch", out_ch, 2'd3);

        // Single requester wins every cycle
        in_valid = 4'b1000;
        #1;
        chk("single_grant", in_ready, 4'b1000);
        repeat (3) begin
            push(3, 8'h33);
            tick();
            chk("single_ch", out_ch, 2'd3);
            chk("single_valid", out_valid, 1'b1);
            chk("single_in_ready", in_ready, 4'b1000);
        end

        // Reset while holding a word from channel 2
        in_valid = 4'b0100;
        #1;
        chk("hold_grant", in_ready, 4'b0100);
        tick();
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        #1;
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_ch", out_ch, 2'd2);
        chk("hold_in_ready", in_ready, 4'b0000);
        tick();
        chk("hold_data", out_data, 8'hA5);
        rst       = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 4'b0000);
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_ch", out_ch, 2'd0);
        chk("midrst_data", out_data, 8'h00);
        chk("midrst_first_grant", in_ready, 4'b0001);
        push(0, 8'h10);
        tick();
        chk("post_rst_ch", out_ch, 2'd0);
        chk("post_rst_data", out_data, 8'h10);
        in_valid = 4'b0000;
        tick();
        chk("final_empty", out_valid, 1'b0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
